xcom_link_rx_ml: RTL and testbench

Parameterised multi-lane successor to the single-lane XCOM wire receiver. It deserialises toggle-clocked frames from NL data lanes that share one strobe wire, and filters them by destination ID. Accepted frames are presented to command processing over a req/ack handshake. It adds a configurable timeout, overrun detection, an error reporting port and a frame counter.

---
 rtl/xcom_link_rx_ml.sv | 175 +++++++++++++++++
 tb/tb_xcom_link_rx_ml.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xcom_link_rx_ml.sv
// xcom_link_rx_ml - multi-lane XCOM wire receiver.
// Deserialises toggle-clocked frames (NL lanes sharing one strobe), filters by
// destination ID and hands accepted frames to the consumer over req/ack.
// Ports:
//   x_clk_i, x_rst_ni         clock, synchronous active-low reset
//   xcom_id_i                 own node ID (0 in dst means broadcast)
//   rx_dt_i, rx_ck_i          async data lanes / strobe (one symbol per level change)
//   rx_req_o, rx_ack_i        frame handshake
//   rx_cmd_o, rx_dst_o        header nibbles of the held frame
//   rx_data_o                 right-aligned payload of the held frame
//   rx_err_o, rx_err_code_o   error pulse, last error (1 timeout, 2 overrun)
//   rx_frm_cnt_o              accepted-frame counter, wrapping
module xcom_link_rx_ml #(
  parameter int NL     = 1,
  parameter int TO_CYC = 31,
  parameter int CNT_W  = 16
) (
  input  logic             x_clk_i,
  input  logic             x_rst_ni,
  input  logic [3:0]       xcom_id_i,
  input  logic [NL-1:0]    rx_dt_i,
  input  logic             rx_ck_i,
  output logic             rx_req_o,
  input  logic             rx_ack_i,
  output logic [3:0]       rx_cmd_o,
  output logic [3:0]       rx_dst_o,
  output logic [31:0]      rx_data_o,
  output logic             rx_err_o,
  output logic [1:0]       rx_err_code_o,
  output logic [CNT_W-1:0] rx_frm_cnt_o
);
  localparam int HDR_SYM = 8 / NL;

  typedef enum logic [2:0] {IDLE, HEADER, DATA, CHECK, REQ, ACK} state_t;
  state_t state;

  logic          ck_s1, ck_s2, ck_s3;
  logic [NL-1:0] dt_s1, dt_s2, dt_s3;
  logic [7:0]    hdr;
  logic [31:0]   shf;
  logic [5:0]    sym_cnt;
  logic [7:0]    to_cnt;

  logic          tog;
  logic [7:0]    hdr_nxt;
  logic [31:0]   shf_nxt;
  logic [5:0]    dat_sym;
  logic          timeout;

  assign tog     = ck_s2 ^ ck_s3;
  assign hdr_nxt = {hdr[7-NL:0], dt_s3};
  assign shf_nxt = {shf[31-NL:0], dt_s3};
  // A tog in the timeout cycle wins, so the abort is qualified with !tog.
  assign timeout = !tog && (state == HEADER || state == DATA) &&
                   (to_cnt == 8'(TO_CYC - 1));

  // Payload symbol count, from the completed header held in hdr.
  always_comb begin
    dat_sym = '0;
    case (hdr[6:5])
      2'b01:   dat_sym = 6'(8 / NL);
      2'b10:   dat_sym = 6'(16 / NL);
      2'b11:   dat_sym = 6'(32 / NL);
      default: dat_sym = '0;
    endcase
  end

  always_ff @(posedge x_clk_i) begin
    if (!x_rst_ni) begin
      state         <= IDLE;
      ck_s1         <= 1'b0;
      ck_s2         <= 1'b0;
      ck_s3         <= 1'b0;
      dt_s1         <= '0;
      dt_s2         <= '0;
      dt_s3         <= '0;
      hdr           <= '0;
      shf           <= '0;
      sym_cnt       <= '0;
      to_cnt        <= '0;
      rx_req_o      <= 1'b0;
      rx_cmd_o      <= '0;
      rx_dst_o      <= '0;
      rx_data_o     <= '0;
      rx_err_o      <= 1'b0;
      rx_err_code_o <= '0;
      rx_frm_cnt_o  <= '0;
    end else begin
      ck_s1 <= rx_ck_i;
      ck_s2 <= ck_s1;
      ck_s3 <= ck_s2;
      dt_s1 <= rx_dt_i;
      dt_s2 <= dt_s1;
      dt_s3 <= dt_s2;
      rx_err_o <= 1'b0;

      if (tog || !(state == HEADER || state == DATA)) to_cnt <= '0;
      else                                           to_cnt <= to_cnt + 8'd1;

      case (state)
        IDLE: begin
          if (tog) begin
            hdr     <= hdr_nxt;
            sym_cnt <= 6'd1;
            state   <= HEADER;
          end else begin
            sym_cnt <= '0;
          end
        end
        HEADER: begin
          if (tog) begin
            hdr <= hdr_nxt;
            if (sym_cnt == 6'(HDR_SYM - 1)) begin
              sym_cnt <= '0;
              shf     <= '0;
              state   <= (|hdr_nxt[6:5]) ? DATA : CHECK;
            end else begin
              sym_cnt <= sym_cnt + 6'd1;
            end
          end else if (timeout) begin
            sym_cnt       <= '0;
            rx_err_o      <= 1'b1;
            rx_err_code_o <= 2'd1;
            state         <= IDLE;
          end
        end
        DATA: begin
          if (tog) begin
            shf <= shf_nxt;
            if (sym_cnt == dat_sym - 6'd1) begin
              sym_cnt <= '0;
              state   <= CHECK;
            end else begin
              sym_cnt <= sym_cnt + 6'd1;
            end
          end else if (timeout) begin
            sym_cnt       <= '0;
            rx_err_o      <= 1'b1;
            rx_err_code_o <= 2'd1;
            state         <= IDLE;
          end
        end
        CHECK: begin
          // Frames for other nodes are dropped silently.
          if (hdr[3:0] == 4'd0 || hdr[3:0] == xcom_id_i) begin
            rx_cmd_o     <= hdr[7:4];
            rx_dst_o     <= hdr[3:0];
            rx_data_o    <= shf;
            rx_frm_cnt_o <= rx_frm_cnt_o + CNT_W'(1);
            rx_req_o     <= 1'b1;
            state        <= REQ;
          end else begin
            state <= IDLE;
          end
        end
        REQ: begin
          if (rx_ack_i) begin
            rx_req_o <= 1'b0;
            state    <= ACK;
          end
        end
        ACK: begin
          if (!rx_ack_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Symbols arriving while a frame is being checked or held are lost.
      if (tog && (state inside {CHECK, REQ, ACK})) begin
        rx_err_o      <= 1'b1;
        rx_err_code_o <= 2'd2;
      end
    end
  end
endmodule

// File: tb/tb_xcom_link_rx_ml.sv
// Bench for xcom_link_rx_ml: three instances (NL = 1, 2, 4) driven by directed
// steps followed by random frames, checked against a frame-level model.
module tb_xcom_link_rx_ml;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n[3];
  logic        ck[3];
  logic [3:0]  dt[3];
  logic        ack[3];
  logic [3:0]  id[3];
  logic        req[3];
  logic [3:0]  cmd[3];
  logic [3:0]  dst[3];
  logic [31:0] data[3];
  logic        err[3];
  logic [1:0]  code[3];
  logic [15:0] cnt[3];

  int vec = 0;
  int mis = 0;
  int exp_cnt[3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = 1 << g;
    xcom_link_rx_ml #(.NL(L), .TO_CYC(31), .CNT_W(16)) dut (
      .x_clk_i(clk), .x_rst_ni(rst_n[g]), .xcom_id_i(id[g]),
      .rx_dt_i(dt[g][L-1:0]), .rx_ck_i(ck[g]),
      .rx_req_o(req[g]), .rx_ack_i(ack[g]),
      .rx_cmd_o(cmd[g]), .rx_dst_o(dst[g]), .rx_data_o(data[g]),
      .rx_err_o(err[g]), .rx_err_code_o(code[g]), .rx_frm_cnt_o(cnt[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vec++;
    assert (obs === expv) else begin
      mis++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Frame-level model
  function automatic int len_of(input logic [3:0] c);
    case (c[2:1])
      2'd0:    return 0;
      2'd1:    return 8;
      2'd2:    return 16;
      default: return 32;
    endcase
  endfunction

  function automatic logic [31:0] exp_data(input logic [3:0] c, input logic [31:0] pl);
    int len = len_of(c);
    if (len == 0)  return 32'h0;
    if (len == 32) return pl;
    return pl & ((32'h1 << len) - 32'h1);
  endfunction

  // Transmit a frame MSB first, NL bits per strobe toggle; maxsym < 0 = whole frame.
  task automatic send(input int u, input logic [3:0] c, input logic [3:0] d,
                      input logic [31:0] pl, input int maxsym);
    int nl = 1 << u;
    int len = len_of(c);
    int total = (8 + len) / nl;
    logic [39:0] v;
    logic [3:0]  s;
    v = {c, d, (len == 0) ? 32'h0 : (pl << (32 - len))};
    if (maxsym >= 0 && maxsym < total) total = maxsym;
    for (int k = 0; k < total; k++) begin
      s = v[39:36] >> (4 - nl);
      dt[u] = s;
      tick(2);
      ck[u] = ~ck[u];
      tick(1);
      v = v << nl;
    end
  endtask

  task automatic wait_req(input int u, input int budget, output int n);
    n = -1;
    for (int k = 1; k <= budget; k++) begin
      tick(1);
      if (req[u] === 1'b1) begin n = k; break; end
    end
  endtask

  task automatic do_ack(input int u);
    ack[u] = 1'b1;
    tick(1);
    chk("req_drop_on_ack", req[u], 0);
    tick($urandom_range(0, 3));
    ack[u] = 1'b0;
    tick(2);
  endtask

  task automatic check_accept(input int u, input logic [3:0] c, input logic [3:0] d,
                              input logic [31:0] pl);
    int n;
    wait_req(u, 20, n);
    chk("req_seen", (n >= 0), 1);
    exp_cnt[u] = (exp_cnt[u] + 1) & 16'hFFFF;
    chk("cmd", cmd[u], c);
    chk("dst", dst[u], d);
    chk("data", data[u], exp_data(c, pl));
    chk("frm_cnt", cnt[u], exp_cnt[u]);
    do_ack(u);
  endtask

  task automatic check_reject(input int u);
    logic seen_req = 1'b0;
    logic seen_err = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      if (req[u] !== 1'b0) seen_req = 1'b1;
      if (err[u] !== 1'b0) seen_err = 1'b1;
    end
    chk("reject_no_req", seen_req, 0);
    chk("reject_no_err", seen_err, 0);
    chk("reject_cnt", cnt[u], exp_cnt[u]);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, c;
    logic seen;
    logic [3:0]  rc, rd;
    logic [31:0] rp;

    for (int u = 0; u < 3; u++) begin
      rst_n[u] = 1'b0; ck[u] = 1'b0; dt[u] = '0; ack[u] = 1'b0; id[u] = 4'd3;
      exp_cnt[u] = 0;
    end
    tick(3);
    for (int u = 0; u < 3; u++) rst_n[u] = 1'b1;
    tick(1);

    // reset state
    for (int u = 0; u < 3; u++) begin
      chk("rst_req", req[u], 0);
      chk("rst_cmd", cmd[u], 0);
      chk("rst_dst", dst[u], 0);
      chk("rst_data", data[u], 0);
      chk("rst_err", err[u], 0);
      chk("rst_code", code[u], 0);
      chk("rst_cnt", cnt[u], 0);
    end

    // broadcast header-only frame, exact request latency
    send(0, 4'h0, 4'h0, 32'h0, -1);
    tick(2);
    chk("lat_early", req[0], 0);
    tick(1);
    chk("lat_req", req[0], 1);
    exp_cnt[0] = 1;
    chk("t1_cmd", cmd[0], 0);
    chk("t1_dst", dst[0], 0);
    chk("t1_data", data[0], 0);
    chk("t1_cnt", cnt[0], 1);
    do_ack(0);

    // 32-bit payload, request held while ack stays low
    send(0, 4'h6, 4'h3, 32'hDEADBEEF, -1);
    wait_req(0, 20, n);
    chk("t2_req", (n >= 0), 1);
    exp_cnt[0] = 2;
    chk("t2_cnt", cnt[0], 2);
    for (int k = 0; k < 100; k++) begin
      tick(1);
      chk("t2_hold", {req[0], cmd[0], dst[0], data[0]}, {1'b1, 4'h6, 4'h3, 32'hDEADBEEF});
    end

    // overrun while the frame is held
    ck[0] = ~ck[0];
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      if (err[0] === 1'b1) begin seen = 1'b1; break; end
    end
    chk("ovr_err", seen, 1);
    tick(1);
    chk("ovr_pulse_end", err[0], 0);
    chk("ovr_code", code[0], 2);
    chk("ovr_req", req[0], 1);
    chk("ovr_data", data[0], 32'hDEADBEEF);
    do_ack(0);

    // NL=4: 16-bit payload, then a frame for another node
    send(2, 4'h4, 4'h0, 32'h0000A5C3, -1);
    check_accept(2, 4'h4, 4'h0, 32'h0000A5C3);
    send(2, 4'h4, 4'h5, 32'h0000A5C3, -1);
    check_reject(2);

    // NL=2: timeout after two header symbols, then a good 8-bit frame
    send(1, 4'h2, 4'h3, 32'h0, 2);
    c = -1;
    for (int k = 1; k <= 60; k++) begin
      tick(1);
      if (err[1] === 1'b1) begin c = k; break; end
    end
    chk("to_not_early", (c >= 31), 1);
    chk("to_not_late", (c >= 0 && c <= 35), 1);
    chk("to_code", code[1], 1);
    chk("to_req", req[1], 0);
    tick(1);
    chk("to_pulse_end", err[1], 0);
    send(1, 4'h2, 4'h3, 32'h7E, -1);
    check_accept(1, 4'h2, 4'h3, 32'h7E);

    // reset in the middle of a frame
    send(0, 4'h6, 4'h3, 32'hDEADBEEF, 28);
    rst_n[0] = 1'b0;
    ck[0] = 1'b0;
    tick(1);
    rst_n[0] = 1'b1;
    exp_cnt[0] = 0;
    chk("mrst_out", {req[0], cmd[0], dst[0], data[0], err[0], code[0], cnt[0]}, 0);
    tick(2);
    send(0, 4'hE, 4'h3, 32'h12345678, -1);
    check_accept(0, 4'hE, 4'h3, 32'h12345678);

    // random frames on every lane width
    for (int u = 0; u < 3; u++) begin
      for (int f = 0; f < 12; f++) begin
        id[u] = 4'($urandom);
        rc = 4'($urandom);
        rp = $urandom;
        case ($urandom_range(0, 2))
          0:       rd = 4'h0;
          1:       rd = id[u];
          default: rd = 4'($urandom);
        endcase
        send(u, rc, rd, rp, -1);
        if (rd == 4'h0 || rd == id[u]) check_accept(u, rc, rd, rp);
        else                           check_reject(u);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
